clken_gen: RTL and testbench



---
 rtl/clken_pkg.sv | 30 +++
 rtl/clken_rst_seq.sv | 86 ++++++++
 rtl/clken_gen.sv | 136 +++++++++++++
 tb/tb_clken_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// clken_pkg: shared types, defaults and decode helpers for the VIC-20
// clock-enable / system-reset sequencer (clken_gen, clken_rst_seq).
package clken_pkg;

  localparam int unsigned DEF_PERIOD   = 25;
  localparam int unsigned DEF_WIN_LOG2 = 4;

  // Low-bit offsets of the decode masks relative to WIN_LOG2:
  // CPU qualifies on div[WIN_LOG2-1-m:0]==0, VIA4 on div[WIN_LOG2-3-m:0]==0.
  localparam int unsigned CPU_MASK_OFS  = 0;
  localparam int unsigned VIA4_MASK_OFS = 2;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } rst_state_t;

  // Number of low div bits that must be zero for a decode hit in mode 'mode'.
  // Zero means every cycle of the active window qualifies.
  function automatic int unsigned mask_width(input int unsigned win_log2,
                                             input int unsigned ofs,
                                             input int unsigned mode);
    int unsigned w;
    if (mode + ofs >= win_log2) w = 0;
    else                        w = win_log2 - ofs - mode;
    return w;
  endfunction

endpackage

// File: rtl/clken_rst_seq.sv
// clken_rst_seq: power-up / request-driven system reset sequencer.
// Synchronises reset_req, runs the PWRUP/RUN/HOLD state machine and counts
// periods using the period tick from clken_gen.
module clken_rst_seq
  import clken_pkg::*;
#(
  parameter int unsigned PWRUP_PERIODS = 1000,
  parameter int unsigned HOLD_PERIODS  = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reset_req,
  input  logic i_period_tick,
  output logic o_sys_reset_n
);

  localparam int unsigned CNT_MAX = (PWRUP_PERIODS > HOLD_PERIODS) ? PWRUP_PERIODS : HOLD_PERIODS;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic          r_req_s1;
  logic          r_req_s2;
  rst_state_t    r_state;
  logic [CW-1:0] r_count;
  logic          r_sys_reset_n;

  // Two-flop synchroniser for the asynchronous reset request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
    end else begin
      r_req_s1 <= i_reset_req;
      r_req_s2 <= r_req_s1;
    end
  end

  // Reset state machine with registered active-low system reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_PWRUP;
      r_count       <= '0;
      r_sys_reset_n <= 1'b0;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (i_period_tick) begin
            if (r_count == CW'(PWRUP_PERIODS)) begin
              r_state       <= ST_RUN;
              r_count       <= '0;
              r_sys_reset_n <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_req_s2) begin
            r_state       <= ST_HOLD;
            r_count       <= CW'(HOLD_PERIODS);
            r_sys_reset_n <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (r_req_s2) begin
            r_count <= CW'(HOLD_PERIODS);
          end else if (i_period_tick) begin
            if (r_count == '0) begin
              r_state       <= ST_RUN;
              r_sys_reset_n <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        default: begin
          r_state       <= ST_PWRUP;
          r_count       <= '0;
          r_sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

  assign o_sys_reset_n = r_sys_reset_n;

endmodule

// File: rtl/clken_gen.sv
// clken_gen: VIC-20 clock-enable generator and system-reset sequencer top.
// Divides clk into PERIOD-cycle slots, emits CPU / VIA phase-2 / VIA 4x
// enables at the turbo rate latched on each period boundary.
// Optional feature macro: CLKEN_PAUSE_EN (pause input latch and gating).
module clken_gen
  import clken_pkg::*;
#(
  parameter int unsigned PERIOD        = DEF_PERIOD,
  parameter int unsigned WIN_LOG2      = DEF_WIN_LOG2,
  parameter int unsigned MODES         = 4,
  parameter int unsigned PWRUP_PERIODS = 1000,
  parameter int unsigned HOLD_PERIODS  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(MODES)-1:0]   turbo,
  input  logic                       pause,
  input  logic                       reset_req,
  output logic                       cpu_clken,
  output logic                       cpu_clken_d1,
  output logic                       via1_clken,
  output logic                       via4_clken,
  output logic [$clog2(MODES)-1:0]   turbo_ack,
  output logic                       period_tick,
  output logic                       sys_reset_n
);

  localparam int unsigned DW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned MW = $clog2(MODES);

  logic [DW-1:0] r_div;
  logic [MW-1:0] r_turbo_s1;
  logic [MW-1:0] r_turbo_s2;
  logic [MW-1:0] r_mode;
  logic          r_cpu_clken;
  logic          r_cpu_clken_d1;
  logic          r_via4_clken;
  logic          r_period_tick;

  logic          w_last;
  logic          w_in_win;
  logic [MW-1:0] w_mode_next;
  logic [31:0]   w_cpu_w;
  logic [31:0]   w_via_w;
  logic [DW-1:0] w_cpu_mask;
  logic [DW-1:0] w_via_mask;
  logic          w_cpu_hit;
  logic          w_via_hit;
  logic          w_gate_en;

  assign w_last = (r_div == DW'(PERIOD - 1));

  // Requested modes beyond the configured range saturate to the fastest mode
  always_comb begin
    w_mode_next = r_turbo_s2;
    if (32'(r_turbo_s2) >= MODES) w_mode_next = MW'(MODES - 1);
  end

  // Enable decode for the current div value and the mode in effect
  always_comb begin
    w_in_win   = (32'(r_div) < (32'd1 << WIN_LOG2));
    w_cpu_w    = mask_width(WIN_LOG2, CPU_MASK_OFS, 32'(r_mode));
    w_via_w    = mask_width(WIN_LOG2, VIA4_MASK_OFS, 32'(r_mode));
    w_cpu_mask = ~({DW{1'b1}} << w_cpu_w);
    w_via_mask = ~({DW{1'b1}} << w_via_w);
    w_cpu_hit  = w_in_win && ((r_div & w_cpu_mask) == '0);
    w_via_hit  = w_in_win && ((r_div & w_via_mask) == '0);
  end

`ifdef CLKEN_PAUSE_EN
  logic r_pause_s1;
  logic r_pause_s2;
  logic r_pause;

  // Synchronise pause and latch it only on the boundary so freezes span whole periods
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
      r_pause    <= 1'b0;
    end else begin
      r_pause_s1 <= pause;
      r_pause_s2 <= r_pause_s1;
      if (w_last) r_pause <= r_pause_s2;
    end
  end

  assign w_gate_en = ~r_pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_gate_en      = 1'b1;
`endif

  // Divider, turbo synchroniser, boundary mode latch and registered enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div          <= '0;
      r_turbo_s1     <= '0;
      r_turbo_s2     <= '0;
      r_mode         <= '0;
      r_cpu_clken    <= 1'b0;
      r_cpu_clken_d1 <= 1'b0;
      r_via4_clken   <= 1'b0;
      r_period_tick  <= 1'b0;
    end else begin
      r_div          <= w_last ? '0 : r_div + 1'b1;
      r_turbo_s1     <= turbo;
      r_turbo_s2     <= r_turbo_s1;
      if (w_last) r_mode <= w_mode_next;
      r_period_tick  <= w_last;
      r_cpu_clken    <= w_cpu_hit & w_gate_en;
      r_via4_clken   <= w_via_hit & w_gate_en;
      r_cpu_clken_d1 <= r_cpu_clken;
    end
  end

  clken_rst_seq #(
    .PWRUP_PERIODS (PWRUP_PERIODS),
    .HOLD_PERIODS  (HOLD_PERIODS)
  ) u_rst_seq (
    .i_clk         (clk),
    .i_rst_n       (reset_n),
    .i_reset_req   (reset_req),
    .i_period_tick (r_period_tick),
    .o_sys_reset_n (sys_reset_n)
  );

  assign cpu_clken    = r_cpu_clken;
  assign cpu_clken_d1 = r_cpu_clken_d1;
  assign via1_clken   = r_cpu_clken;
  assign via4_clken   = r_via4_clken;
  assign turbo_ack    = r_mode;
  assign period_tick  = r_period_tick;

endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: directed, table-driven bench for clken_gen.
module tb_clken_gen;

  localparam int P     = 25;
  localparam int NV    = 24;
`ifdef CLKEN_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] turbo;
  logic       pause;
  logic       reset_req;
  logic       cpu_clken;
  logic       cpu_clken_d1;
  logic       via1_clken;
  logic       via4_clken;
  logic [1:0] turbo_ack;
  logic       period_tick;
  logic       sys_reset_n;

  clken_gen #(
    .PERIOD        (25),
    .WIN_LOG2      (4),
    .MODES         (4),
    .PWRUP_PERIODS (4),
    .HOLD_PERIODS  (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .turbo        (turbo),
    .pause        (pause),
    .reset_req    (reset_req),
    .cpu_clken    (cpu_clken),
    .cpu_clken_d1 (cpu_clken_d1),
    .via1_clken   (via1_clken),
    .via4_clken   (via4_clken),
    .turbo_ack    (turbo_ack),
    .period_tick  (period_tick),
    .sys_reset_n  (sys_reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] turbo;
    int         d;      // div value being decoded
    logic       cpu;
    logic       via4;
  } vec_t;

  vec_t vecs [0:NV-1];
  int   n_checks = 0;
  int   n_errors = 0;
  int   phase    = 0;   // bench's own copy of div

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase == P - 1) ? 0 : phase + 1;
  endtask

  task automatic to_boundary();
    do tick(); while (phase != 0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    turbo = m;
    to_boundary();
    to_boundary();
  endtask

  // Runs one full period from phase 0; applies turbo/pause values at set_ph
  task automatic run_period(input int set_ph, input logic [1:0] t_val, input logic p_val,
                            output int n_cpu, output int n_via1, output int n_via4, output int n_d1);
    n_cpu = 0; n_via1 = 0; n_via4 = 0; n_d1 = 0;
    for (int k = 0; k < P; k++) begin
      tick();
      if (phase == set_ph) begin
        turbo = t_val;
        pause = p_val;
      end
      n_cpu  += int'(cpu_clken);
      n_via1 += int'(via1_clken);
      n_via4 += int'(via4_clken);
      n_d1   += int'(cpu_clken_d1);
    end
  endtask

  // Measures cycles from release to first tick and from first tick to sys_reset_n rise
  task automatic measure_pwrup(input string tag);
    int t_tick, t_rise, bad_tick;
    t_tick = -1; t_rise = -1; bad_tick = 0;
    for (int c = 1; c <= 300 && t_rise < 0; c++) begin
      tick();
      if (period_tick && t_tick < 0) t_tick = c;
      if (period_tick !== (phase == 0)) bad_tick++;
      if (sys_reset_n === 1'b1 && t_rise < 0) t_rise = c;
    end
    check({tag, "_first_tick"}, t_tick, 25);
    check({tag, "_rise_after_tick"}, t_rise - t_tick, 101);
    check({tag, "_tick_only_at_div0"}, bad_tick, 0);
  endtask

  initial begin
    int n_cpu, n_via1, n_via4, n_d1, nb, tgt;
    logic [1:0] cur;
    bit rose;

    // mode, decoded div, expected cpu, expected via4
    vecs[0]  = '{2'd0, 0,  1'b1, 1'b1};
    vecs[1]  = '{2'd0, 1,  1'b0, 1'b0};
    vecs[2]  = '{2'd0, 4,  1'b0, 1'b1};
    vecs[3]  = '{2'd0, 12, 1'b0, 1'b1};
    vecs[4]  = '{2'd0, 15, 1'b0, 1'b0};
    vecs[5]  = '{2'd0, 16, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, 24, 1'b0, 1'b0};
    vecs[7]  = '{2'd1, 0,  1'b1, 1'b1};
    vecs[8]  = '{2'd1, 3,  1'b0, 1'b0};
    vecs[9]  = '{2'd1, 8,  1'b1, 1'b1};
    vecs[10] = '{2'd1, 10, 1'b0, 1'b1};
    vecs[11] = '{2'd1, 16, 1'b0, 1'b0};
    vecs[12] = '{2'd2, 4,  1'b1, 1'b1};
    vecs[13] = '{2'd2, 6,  1'b0, 1'b1};
    vecs[14] = '{2'd2, 8,  1'b1, 1'b1};
    vecs[15] = '{2'd2, 13, 1'b0, 1'b1};
    vecs[16] = '{2'd2, 20, 1'b0, 1'b0};
    vecs[17] = '{2'd3, 0,  1'b1, 1'b1};
    vecs[18] = '{2'd3, 1,  1'b0, 1'b1};
    vecs[19] = '{2'd3, 14, 1'b1, 1'b1};
    vecs[20] = '{2'd3, 15, 1'b0, 1'b1};
    vecs[21] = '{2'd3, 16, 1'b0, 1'b0};
    vecs[22] = '{2'd3, 17, 1'b0, 1'b0};
    vecs[23] = '{2'd3, 24, 1'b0, 1'b0};

    // Reset state with active inputs
    reset_n = 1'b0; turbo = 2'd3; pause = 1'b1; reset_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {cpu_clken, cpu_clken_d1, via1_clken, via4_clken, turbo_ack, period_tick, sys_reset_n}, '0);
    turbo = 2'd0; pause = 1'b0; reset_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; phase = 0;
    check("sysrst_low_after_release", sys_reset_n, 1'b0);

    measure_pwrup("pwrup");

    // Table-driven decode checks
    cur = 2'd0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].turbo != cur) begin
        set_mode(vecs[i].turbo);
        cur = vecs[i].turbo;
      end
      tgt = (vecs[i].d + 1) % P;
      while (phase != tgt) tick();
      check($sformatf("cpu_m%0d_d%0d", cur, vecs[i].d), cpu_clken, vecs[i].cpu);
      check($sformatf("via1_m%0d_d%0d", cur, vecs[i].d), via1_clken, vecs[i].cpu);
      check($sformatf("via4_m%0d_d%0d", cur, vecs[i].d), via4_clken, vecs[i].via4);
      check($sformatf("ack_m%0d_d%0d", cur, vecs[i].d), turbo_ack, cur);
      tick();
      check($sformatf("d1_m%0d_d%0d", cur, vecs[i].d), cpu_clken_d1, vecs[i].cpu);
    end

    // Per-period pulse totals for every mode
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1:0]);
      run_period(-1, m[1:0], 1'b0, n_cpu, n_via1, n_via4, n_d1);
      check($sformatf("cpu_count_m%0d", m), n_cpu, 1 << m);
      check($sformatf("via4_count_m%0d", m), n_via4, (m >= 2) ? 16 : (4 << m));
      check($sformatf("d1_count_m%0d", m), n_d1, 1 << m);
    end

    // Turbo 0 -> 2 requested at div 10: switch only on the next boundary
    set_mode(2'd0);
    check("ack_before_switch", turbo_ack, 2'd0);
    run_period(10, 2'd2, 1'b0, n_cpu, n_via1, n_via4, n_d1);
    check("switch_old_period_cpu", n_cpu, 1);
    check("switch_ack_at_div0", turbo_ack, 2'd2);
    run_period(-1, 2'd2, 1'b0, n_cpu, n_via1, n_via4, n_d1);
    check("switch_new_period_cpu", n_cpu, 4);

    // Pause at div 5 in mode 3: current period completes, then whole periods frozen
    set_mode(2'd3);
    run_period(5, 2'd3, 1'b1, n_cpu, n_via1, n_via4, n_d1);
    check("pause_first_period_cpu", n_cpu, 8);
    check("pause_first_period_via4", n_via4, 16);
    run_period(-1, 2'd3, 1'b1, n_cpu, n_via1, n_via4, n_d1);
    check("pause_frozen_cpu", n_cpu, PAUSE_EN ? 0 : 8);
    check("pause_frozen_via1", n_via1, PAUSE_EN ? 0 : 8);
    check("pause_frozen_via4", n_via4, PAUSE_EN ? 0 : 16);
    check("pause_frozen_d1", n_d1, PAUSE_EN ? 0 : 8);
    run_period(3, 2'd3, 1'b0, n_cpu, n_via1, n_via4, n_d1);
    check("pause_drop_period_cpu", n_cpu, PAUSE_EN ? 0 : 8);
    run_period(-1, 2'd3, 1'b0, n_cpu, n_via1, n_via4, n_d1);
    check("pause_resumed_cpu", n_cpu, 8);
    check("pause_resumed_via4", n_via4, 16);

    // reset_req held 3 clks in RUN
    while (phase != 5) tick();
    check("run_before_req", sys_reset_n, 1'b1);
    reset_req = 1'b1;
    tick(); tick();
    check("req_sync_latency", sys_reset_n, 1'b1);
    tick();
    reset_req = 1'b0;
    check("req_enters_hold", sys_reset_n, 1'b0);
    nb = 0; rose = 1'b0;
    for (int c = 0; c < 30 * P && !rose; c++) begin
      tick();
      if (phase == 0) nb++;
      if (sys_reset_n === 1'b1) rose = 1'b1;
    end
    check("hold_rose", rose, 1'b1);
    check("hold_boundaries", nb, 17);
    check("hold_rise_phase", phase, 1);

    // reset_n asserted mid-HOLD at div 12
    while (phase != 2) tick();
    reset_req = 1'b1;
    tick(); tick(); tick();
    reset_req = 1'b0;
    while (phase != 12) tick();
    check("midhold_sysrst_low", sys_reset_n, 1'b0);
    check("midhold_via4_active", via4_clken, 1'b1);
    check("midhold_ack", turbo_ack, 2'd3);
    reset_n = 1'b0;
    #1;
    check("midhold_async_clear", {cpu_clken, cpu_clken_d1, via1_clken, via4_clken, turbo_ack, period_tick, sys_reset_n}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("midhold_still_clear", {cpu_clken, cpu_clken_d1, via1_clken, via4_clken, turbo_ack, period_tick, sys_reset_n}, '0);
    reset_n = 1'b1; phase = 0;
    measure_pwrup("repwrup");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
